// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard sequencer: stalls on EX/MEM writer hazards, then redirects.
// Optional statistics counters are enabled with `define BRANCH_STATS_EN.
module branch_hazard_ctrl #(
    parameter int ALU_STALL      = 1,
    parameter int LOAD_EX_STALL  = 2,
    parameter int LOAD_MEM_STALL = 1,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [5:0] Op,
    input  logic [4:0] Rt,
    input  logic [5:0] Funct,
    input  logic [4:0] id_rs,
    input  logic       Branch,
    input  logic       Jump,
    input  logic       JumpR,
    input  logic       ex_regwrite,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic       mem_regwrite,
    input  logic       mem_memread,
    input  logic [4:0] mem_rd,
    input  logic       pipe_hold,
`ifdef BRANCH_STATS_EN
    output logic [CNT_W-1:0] stat_cf,
    output logic [CNT_W-1:0] stat_taken,
    output logic [CNT_W-1:0] stat_stall,
`endif
    output logic [1:0] pc_sel,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       busy
);

    localparam int MAX_A = (ALU_STALL > LOAD_EX_STALL) ? ALU_STALL : LOAD_EX_STALL;
    localparam int MAX_S = (MAX_A > LOAD_MEM_STALL) ? MAX_A : LOAD_MEM_STALL;
    localparam int CW    = (MAX_S < 2) ? 1 : $clog2(MAX_S + 1);

    typedef enum logic {IDLE, STALL} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] h;
    logic          cf, use_rs, use_rt;
    logic          ex_hit, mem_hit;

    always_comb begin
        cf     = 1'b0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        case (Op)
            6'd0: begin
                cf     = (Funct == 6'd8);
                use_rs = (Funct == 6'd8);
            end
            6'd1: begin
                cf     = (Rt == 5'd0) || (Rt == 5'd1);
                use_rs = cf;
            end
            6'd2: cf = 1'b1;
            6'd4, 6'd5: begin
                cf     = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            6'd6, 6'd7: begin
                cf     = 1'b1;
                use_rs = 1'b1;
            end
            default: cf = 1'b0;
        endcase
        cf = cf && id_valid;
    end

    // Register 0 is hard-wired, so it can never be a hazard source.
    always_comb begin
        ex_hit  = (ex_rd != 5'd0) &&
                  ((use_rs && id_rs == ex_rd) || (use_rt && Rt == ex_rd));
        mem_hit = (mem_rd != 5'd0) &&
                  ((use_rs && id_rs == mem_rd) || (use_rt && Rt == mem_rd));
        h = '0;
        if (ex_hit && ex_memread && CW'(LOAD_EX_STALL) > h)
            h = CW'(LOAD_EX_STALL);
        if (ex_hit && !ex_memread && ex_regwrite && CW'(ALU_STALL) > h)
            h = CW'(ALU_STALL);
        if (mem_hit && mem_memread && CW'(LOAD_MEM_STALL) > h)
            h = CW'(LOAD_MEM_STALL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        pc_sel      = 2'd0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst) begin
            state_n = IDLE;
        end else if (pipe_hold) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cf && h != '0) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        cnt_n       = h - CW'(1);
                        state_n     = (h > CW'(1)) ? STALL : IDLE;
                    end else if (cf && Branch) begin
                        pc_sel     = Jump ? 2'd2 : (JumpR ? 2'd3 : 2'd1);
                        ifid_flush = 1'b1;
                    end
                end
                STALL: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    if (cnt <= CW'(1)) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy = (state == STALL);

`ifdef BRANCH_STATS_EN
    logic resolved;

    assign resolved = !rst && !pipe_hold && state == IDLE && cf && h == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cf    <= '0;
            stat_taken <= '0;
            stat_stall <= '0;
        end else begin
            if (resolved && stat_cf != '1)
                stat_cf <= stat_cf + 1'b1;
            if (ifid_flush && stat_taken != '1)
                stat_taken <= stat_taken + 1'b1;
            if (idex_bubble && stat_stall != '1)
                stat_stall <= stat_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Scoreboard bench for branch_hazard_ctrl.
// Build with +define+BRANCH_STATS_EN to also check the statistics counters.
module tb_branch_hazard_ctrl;

    typedef struct packed {
        logic [1:0] pc_sel;
        logic       pc_write;
        logic       ifid_write;
        logic       ifid_flush;
        logic       idex_bubble;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [5:0] Op = '0;
    logic [4:0] Rt = '0;
    logic [5:0] Funct = '0;
    logic [4:0] id_rs = '0;
    logic       Branch = 1'b0, Jump = 1'b0, JumpR = 1'b0;
    logic       ex_regwrite = 1'b0, ex_memread = 1'b0;
    logic [4:0] ex_rd = '0;
    logic       mem_regwrite = 1'b0, mem_memread = 1'b0;
    logic [4:0] mem_rd = '0;
    logic       pipe_hold = 1'b0;
    logic [1:0] pc_sel;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, busy;
`ifdef BRANCH_STATS_EN
    logic [15:0] stat_cf, stat_taken, stat_stall;
`endif

    int   checks = 0;
    int   errors = 0;
    int   n_stall = 0;
    int   n_taken = 0;
    exp_t sb[$];

    localparam exp_t NORM  = '{2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam exp_t STL_I = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam exp_t STL_S = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam exp_t HOLD  = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam exp_t HOLDI = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t BR    = '{2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam exp_t JMP   = '{2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam exp_t JR    = '{2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    branch_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .Op(Op), .Rt(Rt),
        .Funct(Funct), .id_rs(id_rs), .Branch(Branch), .Jump(Jump),
        .JumpR(JumpR), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .mem_regwrite(mem_regwrite),
        .mem_memread(mem_memread), .mem_rd(mem_rd), .pipe_hold(pipe_hold),
`ifdef BRANCH_STATS_EN
        .stat_cf(stat_cf), .stat_taken(stat_taken), .stat_stall(stat_stall),
`endif
        .pc_sel(pc_sel), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic idle_in();
        id_valid = 1'b1; Op = 6'd8; Rt = '0; Funct = '0; id_rs = '0;
        Branch = 0; Jump = 0; JumpR = 0;
        ex_regwrite = 0; ex_memread = 0; ex_rd = '0;
        mem_regwrite = 0; mem_memread = 0; mem_rd = '0;
        pipe_hold = 0;
    endtask

    task automatic push(input exp_t e);
        sb.push_back(e);
        if (e.idex_bubble) n_stall++;
        if (e.ifid_flush) n_taken++;
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        exp_t got;
        got = '{pc_sel, pc_write, ifid_write, ifid_flush, idex_bubble, busy};
        if (sb.size() == 0) begin
            check({tag, "_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(tag, 32'(got), 32'(e));
        end
    endtask

    // Inputs are applied 1ns after a rising edge and sampled 3ns later.
    task automatic step(input string tag, input exp_t e);
        push(e);
        #3;
        pop_cmp(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        #2;
        push(NORM);
        pop_cmp("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef BRANCH_STATS_EN
        check("stat_rst", 32'(stat_stall), 32'd0);
`endif
        idle_in(); id_rs = 5'd5; ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd5;
        step("non_cf_addi", NORM);
        idle_in(); Op = 6'd0; Funct = 6'h20; id_rs = 5'd5; Branch = 1;
        ex_regwrite = 1; ex_rd = 5'd5;
        step("non_cf_add", NORM);

        idle_in(); Op = 6'd4; id_rs = 5'd5; Rt = 5'd6; Branch = 1;
        ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd5;
        step("beq_ld_s1", STL_I);
        idle_in(); Op = 6'd4; id_rs = 5'd5; Rt = 5'd6; Branch = 1;
        mem_regwrite = 1; mem_memread = 1; mem_rd = 5'd5;
        step("beq_ld_s2", STL_S);
        idle_in(); Op = 6'd4; id_rs = 5'd5; Rt = 5'd6; Branch = 1;
        step("beq_ld_res", BR);

        idle_in(); Op = 6'd5; id_rs = 5'd3; Rt = 5'd7; Branch = 1;
        ex_regwrite = 1; ex_rd = 5'd7;
        mem_regwrite = 1; mem_memread = 1; mem_rd = 5'd7;
        step("bne_max_s", STL_I);
        idle_in(); Op = 6'd5; id_rs = 5'd3; Rt = 5'd7;
        step("bne_nt", NORM);
        idle_in(); Op = 6'd5; id_rs = 5'd0; Rt = 5'd0; Branch = 1;
        ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd0;
        step("bne_r0", BR);
        idle_in(); Op = 6'd6; id_rs = 5'd9; Branch = 1;
        mem_regwrite = 1; mem_rd = 5'd9;
        step("blez_fwd", BR);

        idle_in(); Op = 6'd2; id_rs = 5'd4; Branch = 1; Jump = 1;
        ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd4;
        step("j_nohaz", JMP);
        idle_in(); Op = 6'd0; Funct = 6'd8; id_rs = 5'd2; Branch = 1; JumpR = 1;
        step("jr", JR);

        idle_in(); Op = 6'd1; Rt = 5'd1; id_rs = 5'd10;
        ex_regwrite = 1; ex_rd = 5'd10; Branch = 1;
        step("bgez_s", STL_I);
        idle_in(); Op = 6'd1; Rt = 5'd1; id_rs = 5'd10; Branch = 1;
        step("bgez_res", BR);
        idle_in(); Op = 6'd1; Rt = 5'd2; id_rs = 5'd10; Branch = 1;
        ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd10;
        step("regimm_x", NORM);
        idle_in(); id_valid = 0; Op = 6'd4; id_rs = 5'd5; Branch = 1;
        ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd5;
        step("no_valid", NORM);

        idle_in(); Op = 6'd4; id_rs = 5'd5; Branch = 1;
        ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd5;
        step("hold_s1", STL_I);
        for (int i = 0; i < 3; i++) begin
            pipe_hold = 1;
            step($sformatf("hold_%0d", i), HOLD);
        end
        idle_in(); Op = 6'd4; id_rs = 5'd5; Branch = 1;
        step("hold_rel", STL_S);
        idle_in(); Op = 6'd4; id_rs = 5'd5; Branch = 1; pipe_hold = 1;
        step("hold_idle", HOLDI);
        pipe_hold = 0;
        step("hold_res", BR);

`ifdef BRANCH_STATS_EN
        check("stat_stall", 32'(stat_stall), 32'(n_stall));
        check("stat_taken", 32'(stat_taken), 32'(n_taken));
`endif

        idle_in(); Op = 6'd4; id_rs = 5'd5; Branch = 1;
        ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd5;
        step("rst_s1", STL_I);
        push(STL_S);
        #1;
        pop_cmp("rst_s2");
        rst = 1'b1;
        #1;
        push(NORM);
        pop_cmp("rst_async");
`ifdef BRANCH_STATS_EN
        check("stat_rst2", 32'(stat_stall), 32'd0);
`endif
        @(posedge clk);
        #1;
        push(NORM);
        pop_cmp("rst_held");
        rst = 1'b0;
        idle_in();
        step("post_rst", NORM);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running want=done");
        $fatal(1);
    end

endmodule
